muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the EX stage of the five-stage MIPS pipeline. It takes the operand pair and operation code that the ID/EX register presents in EX, computes MULT/MULTU/DIV/DIVU over 32 iterations, and holds the result in architectural HI/LO registers. While an operation is in flight it raises a stall request to the hazard logic. It also services MTHI/MTLO writes.

## Interface
Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request a new operation this cycle; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srca  in  WIDTH  rs operand; dividend for divides.
- srcb  in  WIDTH  rt operand; divisor for divides.
- flush  in  1  abort any in-flight operation.
- mthi  in  1  write wdata to HI.
- mtlo  in  1  write wdata to LO.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO receive a new result.
- stall_req  out  1  combinational: busy | start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE with start=1: latch srca, srcb, op and the operand signs. Signed ops (MULT, DIV) latch operand magnitudes. Clear the iteration counter, then go to CALC.
- CALC:
  - One iteration per cycle; WIDTH iterations in total.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle, with a WIDTH+1 bit partial remainder.
  - After the WIDTH-th iteration, go to FIX.
- FIX: apply sign correction and write HI/LO. Pulse done. Go to IDLE.
- Multiply result: the 64-bit product, with HI as the upper half and LO as the lower half.
  - Signed: negate the full 64-bit value if the operand signs differ.
- Divide result: LO is the quotient, HI is the remainder.
  - Signed: the quotient is negative if the signs differ; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
- Divide by zero (signed or unsigned): LO=0xFFFFFFFF, HI=srca. Full latency still applies; there is no exception.
- start while busy is ignored; operands are not re-latched.
- flush in CALC or FIX: return to IDLE at the next edge. HI/LO are unchanged and there is no done pulse. flush in IDLE has no effect and does not block a start in the same cycle; flush takes priority over start only when not IDLE.
- mthi/mtlo:
  - Take effect at the edge only in IDLE with start=0.
  - Ignored while busy or when start=1.
  - Both asserted writes wdata to both HI and LO.
- Reset (asynchronous, any state):
  - state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
  - An in-flight result is discarded.

## Timing
- Edge E0 samples start in IDLE. busy=1 from E0 until E33 (33 cycles).
- Iterations occur on E1..E32. FIX occupies the cycle after E32.
- At E33: hi/lo updated, done=1 for exactly one cycle, busy=0.
- Result latency is 33 cycles after the start edge.
- A new start can be accepted at E33 (state is IDLE during the done cycle), so back-to-back operations are 33 cycles apart.
- stall_req is combinational.
  - High in the start cycle and during busy; low in the done cycle unless a new start is asserted.
  - The pipeline must hold the EX instruction and block MFHI/MFLO while stall_req=1.
- hi/lo change only at FIX exit, on an accepted mthi/mtlo, or on reset.

## Test plan
- Reset: deassert resetn, start MULTU, assert resetn low at cycle 10. Expect busy=0, hi=lo=0 immediately. After release, no done pulse.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - busy high for exactly 33 cycles, done pulse at E33.
  - Expect hi=0xFFFFFFFE, lo=0x00000001.
  - A start asserted at cycle 5 with other operands is ignored.
- MULT 0xFFFFFFFD (-3) × 7: expect hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Divides:
  - DIV 0xFFFFFFF9 (-7) / 2: expect lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7 / 0: expect lo=0xFFFFFFFF, hi=7 after 33 cycles.
  - DIV 0x80000000 / 0xFFFFFFFF: expect lo=0x80000000, hi=0.
- Flush: start DIVU 100/3 with prior hi=0x11, lo=0x22, assert flush at cycle 12.
  - Expect busy=0 next cycle, no done pulse, hi/lo still 0x11/0x22.
  - An immediately following start completes normally: lo=33, hi=1.
- MTHI/MTLO:
  - mthi with wdata=0xA5A5A5A5 while busy: ignored.
  - mtlo with wdata=0x5A5A5A5A in IDLE: lo=0x5A5A5A5A next edge.
  - mthi together with start in IDLE: ignored and the operation starts.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit for the EX stage.
// Computes one bit per cycle over WIDTH cycles, then applies sign correction
// in FIX and writes the architectural HI/LO registers.
// Ports:
//   clock, resetn        rising-edge clock, async active-low reset
//   start, op            launch request (sampled in IDLE), 00 MULT 01 MULTU 10 DIV 11 DIVU
//   srca, srcb           rs/rt operands (dividend/divisor for divides)
//   flush                abort in-flight operation
//   mthi, mtlo, wdata    HI/LO writes, honoured only in IDLE without start
//   busy, done           in-flight flag, one-cycle result pulse
//   stall_req            busy | start, to hazard logic
//   hi, lo               architectural HI/LO
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opa;      // |srca|: multiplicand, or dividend kept for div-by-zero HI
  logic [WIDTH-1:0]   opb;      // |srcb|: divisor
  logic [2*WIDTH-1:0] acc;      // mul: {partial product, multiplier}; div: low half = dividend -> quotient
  logic [WIDTH:0]     rem;      // restoring-divide partial remainder
  logic               sign_a, sign_b, is_div, dz;

  // Signs are only meaningful for signed ops; unsigned ops latch zero.
  logic sa_in, sb_in;
  assign sa_in = ~op[0] & srca[WIDTH-1];
  assign sb_in = ~op[0] & srcb[WIDTH-1];

  // Multiply step: add multiplicand to upper half if multiplier LSB set, then shift right.
  logic [WIDTH:0] madd;
  assign madd = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opa : {WIDTH{1'b0}})};

  // Divide step: shift next dividend bit into the remainder and trial-subtract.
  logic [WIDTH:0] dshift, dsub;
  logic           ge;
  assign dshift = {rem[WIDTH-1:0], acc[WIDTH-1]};
  assign dsub   = dshift - {1'b0, opb};
  assign ge     = dshift >= {1'b0, opb};

  // Sign correction applied on FIX exit.
  logic [2*WIDTH-1:0] fix_res;
  always_comb begin
    fix_res = acc;
    if (!is_div) begin
      if (sign_a ^ sign_b) fix_res = -acc;
    end else if (dz) begin
      fix_res = {(sign_a ? -opa : opa), {WIDTH{1'b1}}};
    end else begin
      fix_res[WIDTH-1:0]       = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fix_res[2*WIDTH-1:WIDTH] = sign_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end
  end

  assign stall_req = busy | start;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      rem    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      is_div <= 1'b0;
      dz     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // flush is a no-op here, so it cannot block a start.
          if (start) begin
            sign_a <= sa_in;
            sign_b <= sb_in;
            is_div <= op[1];
            dz     <= (srcb == '0);
            opa    <= sa_in ? -srca : srca;
            opb    <= sb_in ? -srcb : srcb;
            acc    <= op[1] ? {{WIDTH{1'b0}}, (sa_in ? -srca : srca)}
                            : {{WIDTH{1'b0}}, (sb_in ? -srcb : srcb)};
            rem    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (is_div) begin
              rem <= ge ? dsub : dshift;
              acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ge};
            end else begin
              acc <= {madd, acc[WIDTH-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (!flush) begin
            hi   <= fix_res[2*WIDTH-1:WIDTH];
            lo   <= fix_res[WIDTH-1:0];
            done <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clock = 1'b0, resetn = 1'b0;
  logic         start = 1'b0, flush = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] srca = '0, srcb = '0, wdata = '0;
  logic         busy, done, stall_req;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .resetn(resetn), .start(start), .op(op),
    .srca(srca), .srcb(srcb), .flush(flush), .mthi(mthi), .mtlo(mtlo),
    .wdata(wdata), .busy(busy), .done(done), .stall_req(stall_req),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  int ntot = 0, nbad = 0, ndone = 0;

  always @(posedge clock) begin
    #1;
    if (done) ndone++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: architectural result {hi,lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin p = sa * sb; return 64'(p); end
      2'd1: return {32'h0, a} * {32'h0, b};
      2'd2: if (b == 0) return {a, 32'hFFFF_FFFF};
            else return {32'(sa % sb), 32'(sa / sb)};
      default: if (b == 0) return {a, 32'hFFFF_FFFF};
               else return {a % b, a / b};
    endcase
  endfunction

  // mode: 0 plain, 1 stray start while busy, 2 mthi while busy,
  //       3 mthi with start, 4 flush with start in IDLE
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int mode);
    logic [63:0] e;
    logic [31:0] h0;
    int cyc, nb;
    e = ref_op(o, a, b);
    @(negedge clock);
    op = o; srca = a; srcb = b; start = 1'b1;
    if (mode == 3) begin mthi = 1'b1; wdata = 32'hDEAD_BEEF; end
    if (mode == 4) flush = 1'b1;
    h0 = hi;
    #1 chk("stall_start", 64'(stall_req), 64'd1);
    @(negedge clock);
    start = 1'b0; mthi = 1'b0; flush = 1'b0;
    if (mode == 3) chk("mthi_with_start", 64'(hi), 64'(h0));
    cyc = 0; nb = 0;
    while (!done && cyc < 100) begin
      if (busy) nb++;
      if (cyc == 5 && mode == 1) begin start = 1'b1; op = ~o; srca = 32'h1234; srcb = 32'h5; end
      if (cyc == 5 && mode == 2) begin mthi = 1'b1; wdata = 32'hA5A5_A5A5; end
      if (cyc == 6) begin
        start = 1'b0; mthi = 1'b0;
        if (mode == 2) chk("mthi_busy", 64'(hi), 64'(h0));
      end
      cyc++;
      @(negedge clock);
    end
    chk("latency", 64'(cyc), 64'd33);
    chk("busy_cycles", 64'(nb), 64'd33);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("stall_at_done", 64'(stall_req), 64'd0);
    chk($sformatf("result op%0d %h %h", o, a, b), {hi, lo}, e);
    @(negedge clock);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic mt(input logic h, input logic l, input logic [31:0] d);
    @(negedge clock);
    mthi = h; mtlo = l; wdata = d;
    @(negedge clock);
    mthi = 1'b0; mtlo = 1'b0;
  endtask

  initial begin
    int d0;
    logic [1:0] o;
    logic [31:0] a, b;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    resetn = 1'b1;

    // Async reset mid-operation discards the result
    mt(1'b0, 1'b1, 32'h77);
    chk("mtlo_pre_reset", 64'(lo), 64'h77);
    @(negedge clock);
    op = 2'd1; srca = '1; srcb = '1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_hilo", {hi, lo}, 64'd0);
    d0 = ndone;
    @(negedge clock);
    resetn = 1'b1;
    repeat (40) @(negedge clock);
    chk("no_done_after_rst", 64'(ndone), 64'(d0));

    // Directed cases
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    do_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(2'd3, 32'd7, 32'd0, 0);
    chk("divu_zero", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    do_op(2'd2, 32'hFFFF_FF00, 32'd0, 0);
    chk("div_zero_neg", {hi, lo}, 64'hFFFF_FF00_FFFF_FFFF);

    // Flush mid-operation
    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    @(negedge clock);
    op = 2'd3; srca = 32'd100; srcb = 32'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (11) @(negedge clock);
    flush = 1'b1;
    d0 = ndone;
    @(negedge clock);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
    do_op(2'd3, 32'd100, 32'd3, 0);
    chk("after_flush", {hi, lo}, 64'h0000_0001_0000_0021);
    chk("flush_no_done", 64'(ndone), 64'(d0 + 1));

    // Flush in IDLE does not block start
    do_op(2'd0, 32'd12345, 32'hFFFF_0000, 4);

    // MTHI/MTLO
    mt(1'b0, 1'b1, 32'h5A5A_5A5A);
    chk("mtlo_idle", 64'(lo), 64'h5A5A_5A5A);
    mt(1'b1, 1'b1, 32'h1357_9BDF);
    chk("mt_both", {hi, lo}, 64'h1357_9BDF_1357_9BDF);
    do_op(2'd1, 32'd3, 32'd5, 2);
    do_op(2'd3, 32'd50, 32'd7, 3);

    // Randomized ops against the reference model
    repeat (24) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: a = 32'h8000_0000;
        2: b = 32'($urandom_range(1, 15));
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_op(o, a, b, 0);
    end

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end
endmodule
